// File: rtl/preamble_detect_ctrl_if.sv
// Correlator-facing bundle for the preamble detector: bank scores in,
// detection report and correlator clear out.
interface preamble_detect_ctrl_if #(
  parameter int BANKS      = 16,
  parameter int CORR_WIDTH = 7
);
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

  logic                        enable;
  logic [CORR_WIDTH*BANKS-1:0] corr_dat;
  logic                        corr_vld;
  logic                        all_zeros;
  logic [CORR_WIDTH-1:0]       thresh;
  logic                        det_vld;
  logic [BANK_W-1:0]           det_bank;
  logic [CORR_WIDTH-1:0]       det_peak;
  logic                        corr_clr;
  logic                        busy;

  modport master (
    output enable, corr_dat, corr_vld, all_zeros, thresh,
    input  det_vld, det_bank, det_peak, corr_clr, busy
  );

  modport slave (
    input  enable, corr_dat, corr_vld, all_zeros, thresh,
    output det_vld, det_bank, det_peak, corr_clr, busy
  );
endinterface

// File: rtl/preamble_detect_ctrl.sv
// Preamble detector: waits for silence, then finds the strongest bank over a
// window of valid samples after a threshold crossing, reports it, and holds off.
module preamble_detect_ctrl #(
  parameter int BANKS       = 16,
  parameter int CORR_WIDTH  = 7,
  parameter int PEAK_WINDOW = 8,
  parameter int HOLDOFF     = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  preamble_detect_ctrl_if.slave pd
);

  localparam int               BANK_W    = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam logic [7:0]       WIN_LAST  = 8'(PEAK_WINDOW);
  localparam logic [15:0]      HOLD_LAST = 16'(HOLDOFF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SEARCH,
    S_TRACK,
    S_REPORT,
    S_HOLDOFF
  } state_e;

  state_e                state_q,    state_d;
  logic [7:0]            win_cnt_q,  win_cnt_d;
  logic [15:0]           hold_cnt_q, hold_cnt_d;
  logic [CORR_WIDTH-1:0] peak_q,     peak_d;
  logic [BANK_W-1:0]     bank_q,     bank_d;

  logic [CORR_WIDTH-1:0] max_score;
  logic [BANK_W-1:0]     max_bank;

  // Strict '>' keeps the lowest bank index on ties.
  always_comb begin
    max_score = pd.corr_dat[CORR_WIDTH-1:0];
    max_bank  = '0;
    for (int i = 1; i < BANKS; i++) begin
      if (pd.corr_dat[i*CORR_WIDTH +: CORR_WIDTH] > max_score) begin
        max_score = pd.corr_dat[i*CORR_WIDTH +: CORR_WIDTH];
        max_bank  = BANK_W'(i);
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    hold_cnt_d = hold_cnt_q;
    peak_d     = peak_q;
    bank_d     = bank_q;

    if (!pd.enable) begin
      state_d    = S_IDLE;
      win_cnt_d  = '0;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ARM;

        S_ARM: begin
          if (pd.corr_vld && pd.all_zeros) state_d = S_SEARCH;
        end

        S_SEARCH: begin
          if (pd.corr_vld && (max_score >= pd.thresh)) begin
            peak_d    = max_score;
            bank_d    = max_bank;
            win_cnt_d = 8'd1;
            state_d   = (WIN_LAST == 8'd1) ? S_REPORT : S_TRACK;
          end
        end

        S_TRACK: begin
          if (pd.corr_vld) begin
            if (max_score > peak_q) begin
              peak_d = max_score;
              bank_d = max_bank;
            end
            win_cnt_d = win_cnt_q + 8'd1;
            if (win_cnt_d == WIN_LAST) state_d = S_REPORT;
          end
        end

        // corr_vld is deliberately ignored while the pulse is out.
        S_REPORT: begin
          state_d    = S_HOLDOFF;
          win_cnt_d  = '0;
          hold_cnt_d = '0;
        end

        S_HOLDOFF: begin
          if (pd.corr_vld) begin
            hold_cnt_d = hold_cnt_q + 16'd1;
            if (hold_cnt_d == HOLD_LAST) begin
              state_d    = S_ARM;
              hold_cnt_d = '0;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: reset is synchronous here, so it wins over enable and aborts even a pending REPORT.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) begin
      state_q    <= S_IDLE;
      win_cnt_q  <= '0;
      hold_cnt_q <= '0;
      peak_q     <= '0;
      bank_q     <= '0;
    end else begin
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      peak_q     <= peak_d;
      bank_q     <= bank_d;
    end
  end

  // All outputs are decodes of registered state, never of the inputs.
  assign pd.det_vld  = (state_q == S_REPORT);
  assign pd.corr_clr = (state_q == S_REPORT);
  assign pd.busy     = (state_q == S_TRACK) || (state_q == S_REPORT) ||
                       (state_q == S_HOLDOFF);
  assign pd.det_bank = bank_q;
  assign pd.det_peak = peak_q;

endmodule

// File: tb/tb_preamble_detect_ctrl.sv
// Bench for preamble_detect_ctrl: directed scenarios plus random traffic, all
// checked each cycle against a sample-window reference model.
module tb_preamble_detect_ctrl;

  localparam int BANKS = 16;
  localparam int CW    = 7;
  localparam int PW    = 8;
  localparam int HO    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  preamble_detect_ctrl_if #(.BANKS(BANKS), .CORR_WIDTH(CW)) bus ();

  preamble_detect_ctrl #(
    .BANKS(BANKS), .CORR_WIDTH(CW), .PEAK_WINDOW(PW), .HOLDOFF(HO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pd (bus)
  );

  int sc [BANKS];
  int n_vec = 0;
  int n_err = 0;
  int det_count = 0;
  int last_bank = -1;
  int last_peak = -1;

  // Reference model: phases tracked as flags, the window kept as a queue of
  // per-sample maxima, and the peak picked only when the window is full.
  bit m_active  = 0;
  bit m_silence = 0;
  bit m_report  = 0;
  int m_hold    = 0;
  int m_peak    = 0;
  int m_bank    = 0;
  int win_max [$];
  int win_bank [$];

  always @(posedge clk) begin
    int mx, mb, best;
    mx = 0;
    for (int i = 0; i < BANKS; i++) if (sc[i] > mx) mx = sc[i];
    mb = 0;
    for (int i = BANKS - 1; i >= 0; i--) if (sc[i] == mx) mb = i;

    if (rst) begin
      m_active = 0; m_silence = 0; m_report = 0; m_hold = 0;
      m_peak = 0; m_bank = 0;
      win_max.delete(); win_bank.delete();
    end else if (!bus.enable) begin
      m_active = 0; m_silence = 0; m_report = 0; m_hold = 0;
      win_max.delete(); win_bank.delete();
    end else if (!m_active) begin
      m_active = 1;
    end else if (m_report) begin
      m_report = 0;
      m_hold   = HO;
    end else if (m_hold > 0) begin
      if (bus.corr_vld) m_hold--;
    end else if (!m_silence) begin
      if (bus.corr_vld && bus.all_zeros) m_silence = 1;
    end else if (bus.corr_vld && (win_max.size() > 0 || mx >= int'(bus.thresh))) begin
      win_max.push_back(mx);
      win_bank.push_back(mb);
      if (win_max.size() == PW) begin
        best = 0;
        for (int k = 1; k < PW; k++) if (win_max[k] > win_max[best]) best = k;
        m_peak    = win_max[best];
        m_bank    = win_bank[best];
        m_report  = 1;
        m_silence = 0;
        win_max.delete(); win_bank.delete();
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_vec++;
    if (got !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("det_vld",  bus.det_vld,  int'(m_report));
    check("corr_clr", bus.corr_clr, int'(m_report));
    check("busy",     bus.busy,     int'(m_report || m_hold > 0 || win_max.size() > 0));
    if (m_report) begin
      check("det_bank", bus.det_bank, m_bank);
      check("det_peak", bus.det_peak, m_peak);
    end
    if (bus.det_vld === 1'b1) begin
      det_count++;
      last_bank = int'(bus.det_bank);
      last_peak = int'(bus.det_peak);
    end
  endtask

  task automatic apply(input bit en, input bit v, input bit az, input int thr);
    bus.enable    = en;
    bus.corr_vld  = v;
    bus.all_zeros = az;
    bus.thresh    = CW'(thr);
    for (int i = 0; i < BANKS; i++) bus.corr_dat[i*CW +: CW] = CW'(sc[i]);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clear_scores();
    for (int i = 0; i < BANKS; i++) sc[i] = 0;
  endtask

  task automatic samp(input int bank, input int val, input bit az, input int thr);
    clear_scores();
    sc[bank] = val;
    apply(1'b1, 1'b1, az, thr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_scores();
    apply(1'b0, 1'b0, 1'b0, 0);
    apply(1'b0, 1'b0, 1'b0, 0);
    rst = 1'b0;
  endtask

  task automatic arm_and_silence(input int thr);
    clear_scores();
    apply(1'b1, 1'b0, 1'b0, thr);
    apply(1'b1, 1'b1, 1'b1, thr);
  endtask

  initial begin
    int s1 [9] = '{10, 22, 30, 25, 24, 23, 22, 21, 20};
    int s2 [8] = '{50, 61, 61, 33, 60, 45, 40, 59};
    bit en, v, az;
    int thr;

    // Reset state and the basic arm/threshold/peak flow.
    do_reset();
    check("rst_peak", bus.det_peak, 0);
    check("rst_bank", bus.det_bank, 0);
    arm_and_silence(20);
    foreach (s1[i]) samp(5, s1[i], 1'b0, 20);
    check("basic_count", det_count, 1);
    check("basic_bank",  last_bank, 5);
    check("basic_peak",  last_peak, 30);

    // Holdoff: the REPORT-cycle sample and four more are ignored.
    samp(7, 60, 1'b0, 20);
    for (int i = 0; i < HO; i++) samp(7, 60, 1'b0, 20);
    check("holdoff_count", det_count, 1);
    samp(7, 60, 1'b1, 20);
    foreach (s2[i]) samp(2, s2[i], 1'b0, 20);
    check("second_count", det_count, 2);
    check("second_bank",  last_bank, 2);
    check("second_peak",  last_peak, 61);

    // No silence ever seen: strong scores never trigger.
    do_reset();
    clear_scores();
    apply(1'b1, 1'b0, 1'b0, 20);
    for (int i = 0; i < 20; i++) samp(4, 60, 1'b0, 20);
    check("nosil_count", det_count, 2);
    check("nosil_busy",  bus.busy, 0);

    // Tie-break towards the lower bank index.
    do_reset();
    arm_and_silence(20);
    clear_scores(); sc[3] = 40; sc[9] = 40;
    apply(1'b1, 1'b1, 1'b0, 20);
    samp(9, 40, 1'b0, 20);
    for (int i = 0; i < PW - 2; i++) samp(9, 35, 1'b0, 20);
    check("tie_count", det_count, 3);
    check("tie_bank",  last_bank, 3);
    check("tie_peak",  last_peak, 40);

    // Abort by enable drop mid-window.
    do_reset();
    arm_and_silence(20);
    for (int i = 0; i < 3; i++) samp(6, 50, 1'b0, 20);
    check("track_busy", bus.busy, 1);
    clear_scores();
    apply(1'b0, 1'b0, 1'b0, 20);
    check("abort_en_busy", bus.busy, 0);
    // Abort by reset mid-window.
    arm_and_silence(20);
    for (int i = 0; i < 3; i++) samp(6, 50, 1'b0, 20);
    rst = 1'b1;
    samp(6, 50, 1'b0, 20);
    rst = 1'b0;
    check("abort_rst_busy", bus.busy, 0);
    // Reset on the edge that would accept the final window sample.
    arm_and_silence(20);
    for (int i = 0; i < PW - 1; i++) samp(6, 50, 1'b0, 20);
    rst = 1'b1;
    samp(6, 55, 1'b0, 20);
    rst = 1'b0;
    check("abort_rpt_det", bus.det_vld, 0);
    check("abort_count",   det_count, 3);

    // Gapped valid: one valid sample every third cycle.
    do_reset();
    arm_and_silence(20);
    for (int k = 0; k < 3 * PW; k++) begin
      if (k % 3 == 2) samp(11, 25 + k, 1'b0, 20);
      else begin
        clear_scores();
        apply(1'b1, 1'b0, 1'b0, 20);
      end
    end
    check("gap_det",   bus.det_vld, 1);
    check("gap_bank",  last_bank, 11);
    check("gap_peak",  last_peak, 25 + 3 * PW - 1);

    // Zero threshold: all-zero scores still cross; bank 0 wins the tie.
    do_reset();
    arm_and_silence(0);
    for (int i = 0; i < PW; i++) begin
      clear_scores();
      apply(1'b1, 1'b1, 1'b0, 0);
    end
    check("thr0_count", det_count, 5);
    check("thr0_bank",  last_bank, 0);
    check("thr0_peak",  last_peak, 0);

    // Random traffic against the model.
    do_reset();
    en  = 1'b1;
    thr = 60;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 249) == 0) en = ~en;
      if (!en) thr = $urandom_range(0, 127);
      v  = ($urandom_range(0, 1) == 1);
      az = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < BANKS; i++)
        sc[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 40);
      apply(en, v, az, thr);
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/preamble_detect_ctrl.md
PREAMBLE_DETECT_CTRL -- requirements
Module: preamble_detect_ctrl

Interface
REQ-001 Parameter BANKS, default 16, SHALL be the number of correlator banks presented on corr_dat.
REQ-002 Parameter CORR_WIDTH, default 7, SHALL be the width of one bank score.
REQ-003 Parameter PEAK_WINDOW, default 8, SHALL be the number of valid samples in a peak-search window (range 1..255).
REQ-004 Parameter HOLDOFF, default 256, SHALL be the number of valid samples ignored after a detection (range 1..65535).
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-007 enable  input  1  SHALL enable detection when high.
REQ-008 corr_dat  input  CORR_WIDTH*BANKS  SHALL carry bank scores, bank i at bits [i*CORR_WIDTH +: CORR_WIDTH], unsigned.
REQ-009 corr_vld  input  1  SHALL qualify corr_dat and all_zeros for one cycle.
REQ-010 all_zeros  input  1  SHALL indicate silence in the correlator input history.
REQ-011 thresh  input  CORR_WIDTH  SHALL be the detection threshold (unsigned, held stable while enable is high).
REQ-012 det_vld  output  1  SHALL pulse high for exactly one cycle per detection.
REQ-013 det_bank  output  $clog2(BANKS)  SHALL give the winning bank index, valid while det_vld is high.
REQ-014 det_peak  output  CORR_WIDTH  SHALL give the winning score, valid while det_vld is high.
REQ-015 corr_clr  output  1  SHALL pulse high in the same cycle as det_vld to request correlator reset.
REQ-016 busy  output  1  SHALL be high in TRACK, REPORT and HOLDOFF.

Function
REQ-017 Per valid sample, the block SHALL compute the maximum bank score; ties SHALL resolve to the lowest bank index.
REQ-018 States SHALL be IDLE, ARM, SEARCH, TRACK, REPORT and HOLDOFF; only corr_vld cycles SHALL advance ARM, SEARCH, TRACK and HOLDOFF.
REQ-019 IDLE -> ARM SHALL occur on the first cycle with enable high.
REQ-020 ARM -> SEARCH SHALL occur on a valid sample with all_zeros high; the block SHALL NOT detect before silence has been seen.
REQ-021 SEARCH -> TRACK SHALL occur on a valid sample whose maximum score is >= thresh; that sample SHALL be window sample 1 and SHALL load the peak register and bank register.
REQ-022 In TRACK, the peak register SHALL update only when a later sample maximum is strictly greater; otherwise the earlier sample SHALL be kept.
REQ-023 After window sample PEAK_WINDOW has been accepted, the state SHALL go to REPORT; with PEAK_WINDOW=1 it SHALL go straight from SEARCH to REPORT.
REQ-024 REPORT SHALL last exactly one cycle: det_vld=1, corr_clr=1, and det_bank/det_peak equal to the peak registers; it SHALL then go to HOLDOFF and ignore corr_vld in that cycle.
REQ-025 HOLDOFF SHALL count HOLDOFF valid samples with a 16-bit counter, then go to ARM.
REQ-026 Detection latency SHALL be one cycle: det_vld is high in the cycle after the clock edge that accepts the final window sample.
REQ-027 thresh=0 SHALL make every valid sample in SEARCH a crossing; a score equal to thresh SHALL count as a crossing.
REQ-028 Deasserting enable in any state SHALL force IDLE on the next edge.
REQ-029 A REPORT already entered SHALL still complete its pulse.
REQ-030 Window and holdoff counters SHALL clear on entry to IDLE.
REQ-031 Outputs SHALL be driven from registers or from the state register only, with no combinational path from inputs.

Reset
REQ-032 On rst, state SHALL be IDLE, counters and the peak and bank registers SHALL be 0, and det_vld, corr_clr and busy SHALL be 0 in the cycle after the reset edge.
REQ-033 rst SHALL take priority over enable and corr_vld, and SHALL abort any state, including REPORT, without emitting det_vld.

Verification
REQ-034 Arm then threshold: enable=1, all_zeros=1 sample, thresh=20, bank 5 scores 10,22,30,25,... for 8 samples -> one det_vld pulse with det_bank=5, det_peak=30, corr_clr=1.
REQ-035 No silence: enable=1, all_zeros never high, scores 60 -> det_vld never asserts and the state stays ARM.
REQ-036 Tie-break: banks 3 and 9 both score 40 on the peak sample, and a later sample has bank 9 = 40 -> det_bank=3, det_peak=40.
REQ-037 Holdoff: HOLDOFF=4, after a detection feed 4 valid samples above thresh with all_zeros=0 -> no detection; then all_zeros=1 and a crossing -> second detection.
REQ-038 Abort: drop enable mid-TRACK, or assert rst mid-TRACK -> no det_vld, state IDLE, and busy=0 the next cycle.
REQ-039 Gapped valid: corr_vld high every 3rd cycle -> the window counts only valid samples, and det_vld is 1 cycle after the 8th valid sample's edge.
